move_controller: RTL
====================

Name: move_controller

Overview:
- Turn-sequencing stage directly upstream of the 7x7 board/win-detect block.
- Converts player cursor and place buttons into one-cycle go/x/y/color load commands.
- Rejects moves onto occupied cells, alternates black/white, and samples the board's win state after each move.
- Declares win or draw and freezes play until reset.

Parameters:
- BOARD_N, 7, board side length; legal coordinates are 0..BOARD_N-1.
- COORD_W, 3, coordinate width; must satisfy 2^COORD_W >= BOARD_N.
- MAX_MOVES, 49, moves until board full (BOARD_N*BOARD_N).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset; same net drives the board block
- btn_up  in  1  cursor y-1 request; synchronous pre-debounced level
- btn_down  in  1  cursor y+1 request; level
- btn_left  in  1  cursor x-1 request; level
- btn_right  in  1  cursor x+1 request; level
- btn_place  in  1  place stone at cursor; level
- win_state  in  2  from board: 0 none, 1 black win, 2 white win, 3 unused
- go  out  1  one-cycle board load strobe
- x  out  COORD_W  row of the move being loaded
- y  out  COORD_W  column of the move being loaded
- color  out  1  side to move: 0 black, 1 white
- cursor_x  out  COORD_W  current cursor row, for display
- cursor_y  out  COORD_W  current cursor column, for display
- move_count  out  6  stones placed so far
- illegal  out  1  one-cycle pulse when place is attempted on an occupied cell
- game_over  out  1  high once a win or draw is decided
- winner  out  2  0 none/draw, 1 black, 2 white
- draw  out  1  high when the board is full and there is no winner

Behaviour:
- All outputs are registered. Reset (resetn=0 at posedge clk) sets:
  - go=0, x=0, y=0, color=0
  - cursor_x=3, cursor_y=3
  - move_count=0, illegal=0, game_over=0, winner=0, draw=0
  - occupancy map cleared, FSM to S_WAIT, edge detectors' previous-value registers cleared
- Every button acts on its rising edge only (prev=0, now=1). A held button produces one action.
- Internal occupancy map: BOARD_N*BOARD_N bits, set at (x,y) in the cycle go is asserted.
- FSM states:
  - S_WAIT: cursor moves on rising edges, wrapping 6->0 and 0->6.
    - Up and down rising in the same cycle: no vertical move. Left and right in the same cycle: no horizontal move. The two axes update independently.
    - Place rising on an empty cell: latch x=cursor_x, y=cursor_y (cursor value before any same-cycle move), go to S_ISSUE.
    - Place rising on an occupied cell: illegal=1 for exactly one cycle, stay in S_WAIT.
  - S_ISSUE: go=1 for exactly this one cycle with stable x/y/color. Set the occupancy bit, increment move_count, go to S_CHECK.
  - S_CHECK: the board has loaded and win_state reflects the new stone. Sample win_state.
    - win_state in {1,2}: winner=win_state, game_over=1, go to S_OVER.
    - Else if move_count==MAX_MOVES: draw=1, game_over=1, go to S_OVER.
    - Else toggle color, return to S_WAIT.
    - win_state==3 is treated as 0.
  - S_OVER: all buttons ignored, go stays 0, outputs hold. Only resetn exits.
- Button edges arriving in S_ISSUE/S_CHECK are discarded, not queued.
- Minimum press-to-go latency is 1 cycle; the next move is accepted no earlier than 3 cycles after the previous place edge.
- move_count saturates at MAX_MOVES; it cannot exceed it because S_OVER is entered.
- Reset mid-move (in S_ISSUE or S_CHECK): immediate return to reset values, no go emitted afterwards. The board clears on the same edge.

Decomposition:
- Package gomoku_pkg:
  - BOARD_N, COORD_W, MAX_MOVES
  - win_state encodings WIN_NONE=0, WIN_BLACK=1, WIN_WHITE=2
  - color encodings COLOR_BLACK=0, COLOR_WHITE=1
  - FSM state enum (S_WAIT, S_ISSUE, S_CHECK, S_OVER)
- One sub-module, rise_detect: 1-bit registered previous value, synchronous active-low reset, output = in & ~prev. Instantiated five times, once per button.

Test Plan:
- Reset, then press place once with win_state=0 -> go=1 for one cycle with x=3,y=3,color=0. move_count=1, color=1 afterwards, cursor stays (3,3).
- Press right 4 times from (3,3) -> cursor_x 4,5,6,0. Hold right for 10 cycles -> exactly one step. Press up and down in the same cycle -> cursor_y unchanged.
- After placing at (3,3), press place again at (3,3) -> illegal pulses for 1 cycle, no go, move_count stays 1, color unchanged.
- Place five black stones at (0,0)..(4,0) interleaved with white moves. Board model drives win_state=1 in the cycle after the fifth black go -> game_over=1, winner=1. Further presses produce no go and no cursor change.
- Fill all 49 cells in alternating turns with win_state held 0 -> after the 49th go: draw=1, game_over=1, winner=0, move_count=49.
- Press place, then assert resetn=0 during S_CHECK -> next cycle all outputs at reset values, no further go. Play resumes normally after resetn=1.

Source files
------------

// File: rtl/gomoku_pkg.sv
// Shared constants, encodings and helpers for the gomoku move-sequencing slice.
package gomoku_pkg;

   localparam int BOARD_N   = 7;
   localparam int COORD_W   = 3;
   localparam int MAX_MOVES = BOARD_N * BOARD_N;
   localparam int CNT_W     = 6;
   localparam int CELLS     = BOARD_N * BOARD_N;
   localparam int IDX_W     = 6;

   localparam logic [1:0] WIN_NONE  = 2'd0;
   localparam logic [1:0] WIN_BLACK = 2'd1;
   localparam logic [1:0] WIN_WHITE = 2'd2;

   localparam logic COLOR_BLACK = 1'b0;
   localparam logic COLOR_WHITE = 1'b1;

   localparam logic [COORD_W-1:0] CURSOR_HOME = COORD_W'(3);

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_ISSUE = 2'd1,
      S_CHECK = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   // Opposing requests on one axis cancel; otherwise step with wraparound.
   function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                     input logic inc,
                                                     input logic dec);
      logic [COORD_W-1:0] r;
      r = c;
      if (inc && !dec) begin
         r = (c == COORD_W'(BOARD_N-1)) ? '0 : c + 1'b1;
      end else if (dec && !inc) begin
         r = (c == '0) ? COORD_W'(BOARD_N-1) : c - 1'b1;
      end
      return r;
   endfunction

   function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] row,
                                                 input logic [COORD_W-1:0] col);
      return IDX_W'(row) * IDX_W'(BOARD_N) + IDX_W'(col);
   endfunction

endpackage

// File: rtl/move_controller_if.sv
// Button/board-side signal bundle of the move controller.
interface move_controller_if;
   import gomoku_pkg::*;

   logic                btn_up;
   logic                btn_down;
   logic                btn_left;
   logic                btn_right;
   logic                btn_place;
   logic [1:0]          win_state;
   logic                go;
   logic [COORD_W-1:0]  x;
   logic [COORD_W-1:0]  y;
   logic                color;
   logic [COORD_W-1:0]  cursor_x;
   logic [COORD_W-1:0]  cursor_y;
   logic [CNT_W-1:0]    move_count;
   logic                illegal;
   logic                game_over;
   logic [1:0]          winner;
   logic                draw;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, btn_place, win_state,
      input  go, x, y, color, cursor_x, cursor_y, move_count,
             illegal, game_over, winner, draw
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, btn_place, win_state,
      output go, x, y, color, cursor_x, cursor_y, move_count,
             illegal, game_over, winner, draw
   );

endinterface

// File: rtl/move_controller_rise_detect.sv
// Rising-edge detector for one pre-debounced button level.
module rise_detect (
   input  logic clk,
   input  logic resetn,
   input  logic in_lvl,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   always_comb prev_d = in_lvl;

   always_ff @(posedge clk) begin
      if (!resetn) prev_q <= 1'b0;
      else         prev_q <= prev_d;
   end

   assign rise = in_lvl & ~prev_q;

endmodule

// File: rtl/move_controller.sv
// Turn sequencer: cursor, place, legality, colour alternation and win/draw latch.
//   state   | meaning
//   S_WAIT  | cursor moves; place edge on empty cell latches the move
//   S_ISSUE | go high one cycle; occupancy and move count update
//   S_CHECK | board has loaded the stone; sample win_state
//   S_OVER  | win or draw decided; frozen until reset
module move_controller
   import gomoku_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   move_controller_if.slave   bus
);

   logic rise_up, rise_down, rise_left, rise_right, rise_place;

   rise_detect u_rd_up    (.clk(clk), .resetn(resetn), .in_lvl(bus.btn_up),    .rise(rise_up));
   rise_detect u_rd_down  (.clk(clk), .resetn(resetn), .in_lvl(bus.btn_down),  .rise(rise_down));
   rise_detect u_rd_left  (.clk(clk), .resetn(resetn), .in_lvl(bus.btn_left),  .rise(rise_left));
   rise_detect u_rd_right (.clk(clk), .resetn(resetn), .in_lvl(bus.btn_right), .rise(rise_right));
   rise_detect u_rd_place (.clk(clk), .resetn(resetn), .in_lvl(bus.btn_place), .rise(rise_place));

   state_t              state_q, state_d;
   logic [COORD_W-1:0]  cursor_x_q, cursor_x_d;
   logic [COORD_W-1:0]  cursor_y_q, cursor_y_d;
   logic [COORD_W-1:0]  x_q, x_d;
   logic [COORD_W-1:0]  y_q, y_d;
   logic                color_q, color_d;
   logic [CNT_W-1:0]    move_count_q, move_count_d;
   logic                go_q, go_d;
   logic                illegal_q, illegal_d;
   logic                game_over_q, game_over_d;
   logic [1:0]          winner_q, winner_d;
   logic                draw_q, draw_d;
   logic [CELLS-1:0]    occ_q, occ_d;

   logic [1:0] win_eff;
   logic       cursor_occupied;
   logic       board_full;
   logic       has_winner;

   // Encoding 3 is reserved by the board and never counts as a win.
   assign win_eff         = (bus.win_state == 2'd3) ? WIN_NONE : bus.win_state;
   assign has_winner      = (win_eff == WIN_BLACK) || (win_eff == WIN_WHITE);
   assign cursor_occupied = occ_q[cell_idx(cursor_x_q, cursor_y_q)];
   assign board_full      = (move_count_q == CNT_W'(MAX_MOVES));

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= S_WAIT;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT:  if (rise_place && !cursor_occupied) state_d = S_ISSUE;
         S_ISSUE: state_d = S_CHECK;
         S_CHECK: state_d = (has_winner || board_full) ? S_OVER : S_WAIT;
         S_OVER:  state_d = S_OVER;
         default: state_d = S_WAIT;
      endcase
   end

   always_comb begin
      cursor_x_d   = cursor_x_q;
      cursor_y_d   = cursor_y_q;
      x_d          = x_q;
      y_d          = y_q;
      color_d      = color_q;
      move_count_d = move_count_q;
      illegal_d    = 1'b0;
      game_over_d  = game_over_q;
      winner_d     = winner_q;
      draw_d       = draw_q;
      occ_d        = occ_q;
      go_d         = (state_d == S_ISSUE);
      case (state_q)
         S_WAIT: begin
            // The move uses the cursor as it stood before any same-cycle step.
            if (rise_place) begin
               if (cursor_occupied) begin
                  illegal_d = 1'b1;
               end else begin
                  x_d = cursor_x_q;
                  y_d = cursor_y_q;
               end
            end
            cursor_x_d = step_coord(cursor_x_q, rise_right, rise_left);
            cursor_y_d = step_coord(cursor_y_q, rise_down, rise_up);
         end
         S_ISSUE: begin
            occ_d[cell_idx(x_q, y_q)] = 1'b1;
            if (!board_full) move_count_d = move_count_q + 1'b1;
         end
         S_CHECK: begin
            if (has_winner) begin
               winner_d    = win_eff;
               game_over_d = 1'b1;
            end else if (board_full) begin
               draw_d      = 1'b1;
               game_over_d = 1'b1;
            end else begin
               color_d = ~color_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cursor_x_q   <= CURSOR_HOME;
         cursor_y_q   <= CURSOR_HOME;
         x_q          <= '0;
         y_q          <= '0;
         color_q      <= COLOR_BLACK;
         move_count_q <= '0;
         go_q         <= 1'b0;
         illegal_q    <= 1'b0;
         game_over_q  <= 1'b0;
         winner_q     <= WIN_NONE;
         draw_q       <= 1'b0;
         occ_q        <= '0;
      end else begin
         cursor_x_q   <= cursor_x_d;
         cursor_y_q   <= cursor_y_d;
         x_q          <= x_d;
         y_q          <= y_d;
         color_q      <= color_d;
         move_count_q <= move_count_d;
         go_q         <= go_d;
         illegal_q    <= illegal_d;
         game_over_q  <= game_over_d;
         winner_q     <= winner_d;
         draw_q       <= draw_d;
         occ_q        <= occ_d;
      end
   end

   assign bus.go         = go_q;
   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.color      = color_q;
   assign bus.cursor_x   = cursor_x_q;
   assign bus.cursor_y   = cursor_y_q;
   assign bus.move_count = move_count_q;
   assign bus.illegal    = illegal_q;
   assign bus.game_over  = game_over_q;
   assign bus.winner     = winner_q;
   assign bus.draw       = draw_q;

endmodule
